// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path (serial_sram_writer and
// serial_edge_sync): default geometry and the two FSM state types.
package serial_pkg;

  localparam int unsigned LANES_C       = 3;   // serial data lanes
  localparam int unsigned DATA_W_C      = 16;  // bits per word per lane
  localparam int unsigned ADDR_W_C      = 18;  // SRAM word-address width
  localparam int unsigned SYNC_STAGES_C = 2;   // synchroniser depth

  typedef enum logic {IDLE, FRAME}    frame_state_t;
  typedef enum logic {W_IDLE, W_WRITE} wr_state_t;

endpackage

// File: rtl/serial_edge_sync.sv
// Multi-stage synchroniser with rising/falling edge detect for a bundle of
// asynchronous inputs. All bits pass through the same number of stages so
// that signals launched together stay aligned after synchronisation.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset, clears every flop
//   d_i     : asynchronous input bundle
//   q_o     : synchronised bundle
//   rise_o  : one-cycle pulse per bit on a synchronised 0->1 transition
//   fall_o  : one-cycle pulse per bit on a synchronised 1->0 transition
module serial_edge_sync #(
  parameter int W           = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] stage_q [SYNC_STAGES];
  logic [W-1:0] prev_q;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its predecessor held before the clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < SYNC_STAGES; s++) stage_q[s] <= stage_q[s-1];
      prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = stage_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/serial_sram_writer.sv
// Receives a framed multi-lane serial stream, deserialises one DATA_W-bit
// word per lane and writes each word group to SRAM through a Wishbone master.
//   wb_clk_i / wb_rst_i : system clock, synchronous active-high reset
//   base_adr_i          : start word address, sampled at frame start
//   serial_clk_i/cyc_i/dat_i : asynchronous serial bit clock, frame, lanes
//   sram_wb_*           : Wishbone master write port
//   busy_o              : frame active or a word group still being written
//   overrun_o           : sticky, a group completed while the previous drained
//   partial_o           : sticky, frame ended mid-word
//   words_o             : words written in the current or last frame
module serial_sram_writer
  import serial_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_C,
  parameter int DATA_W      = DATA_W_C,
  parameter int LANES       = LANES_C,
  parameter int SYNC_STAGES = SYNC_STAGES_C
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [ADDR_W-1:0] base_adr_i,
  input  logic              serial_clk_i,
  input  logic              serial_cyc_i,
  input  logic [LANES-1:0]  serial_dat_i,
  output logic              sram_wb_cyc_o,
  output logic              sram_wb_stb_o,
  output logic              sram_wb_we_o,
  output logic [ADDR_W-1:0] sram_wb_adr_o,
  output logic [DATA_W-1:0] sram_wb_dat_o,
  input  logic              sram_wb_ack_i,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              partial_o,
  output logic [ADDR_W-1:0] words_o
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SW = LANES + 2;

  // Synchronised serial inputs: {clk, cyc, lanes}
  logic [SW-1:0]    sync_q, sync_rise, sync_fall;
  logic             sclk_rise, cyc_s, cyc_rise;
  logic [LANES-1:0] dat_s;
  logic             unused_sync;

  serial_edge_sync #(.W(SW), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .d_i    ({serial_clk_i, serial_cyc_i, serial_dat_i}),
    .q_o    (sync_q),
    .rise_o (sync_rise),
    .fall_o (sync_fall)
  );

  assign sclk_rise   = sync_rise[SW-1];
  assign cyc_s       = sync_q[SW-2];
  assign cyc_rise    = sync_rise[SW-2];
  assign dat_s       = sync_q[LANES-1:0];
  assign unused_sync = ^{sync_rise[LANES-1:0], sync_fall};

  // Frame-side state
  frame_state_t         frame_q;
  logic [SYNC_STAGES:0] flush_q;    // fills with ones once the synchroniser holds real input
  logic                 armed_q;    // cyc seen low since reset
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]    adr_cnt_q;
  logic [DATA_W-1:0]    shift_q [LANES];
  logic                 grp_done_q; // cycle E+1: shift registers hold a full group
  logic                 frame_start, grp_end;

  // Write-side state
  wr_state_t            wr_q;
  logic                 pend_q;
  logic [LW-1:0]        lane_q;
  logic [ADDR_W-1:0]    grp_adr_q;
  logic [DATA_W-1:0]    buf_q [LANES];

  // NOTE: every signal driven here gets a value on every path (defaults
  // first), so no latches are inferred.
  always_comb begin
    frame_start = 1'b0;
    grp_end     = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    if (frame_q == IDLE && cyc_rise && armed_q) frame_start = 1'b1;
    if (sclk_rise) begin
      grp_end   = (bit_cnt_q == BW'(DATA_W-1));
      bit_cnt_d = grp_end ? '0 : bit_cnt_q + BW'(1);
    end
  end

  // Frame FSM and deserialiser
  // NOTE: the shift-register array is cleared on reset because a discarded
  // partial word must never leak into a later group.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      frame_q    <= IDLE;
      flush_q    <= '0;
      armed_q    <= 1'b0;
      bit_cnt_q  <= '0;
      adr_cnt_q  <= '0;
      grp_done_q <= 1'b0;
      overrun_o  <= 1'b0;
      partial_o  <= 1'b0;
      for (int l = 0; l < LANES; l++) shift_q[l] <= '0;
    end else begin
      flush_q    <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      grp_done_q <= 1'b0;
      if (flush_q[SYNC_STAGES] && !cyc_s) armed_q <= 1'b1;
      if (grp_done_q) adr_cnt_q <= adr_cnt_q + ADDR_W'(LANES);

      case (frame_q)
        IDLE: begin
          if (frame_start) begin
            frame_q   <= FRAME;
            adr_cnt_q <= base_adr_i;
            bit_cnt_q <= '0;
            overrun_o <= 1'b0;
            partial_o <= 1'b0;
          end
        end
        FRAME: begin
          if (sclk_rise) begin
            for (int l = 0; l < LANES; l++)
              shift_q[l] <= {shift_q[l][DATA_W-2:0], dat_s[l]};
            bit_cnt_q <= bit_cnt_d;
            if (grp_end) begin
              // A busy buffer drops the group, but the address still
              // advances so later groups land where the source expects.
              if (pend_q) begin
                overrun_o <= 1'b1;
                adr_cnt_q <= adr_cnt_q + ADDR_W'(LANES);
              end else begin
                grp_done_q <= 1'b1;
              end
            end
          end
          // The edge above is processed before the frame closes.
          if (!cyc_s) begin
            frame_q   <= IDLE;
            bit_cnt_q <= '0;
            if (bit_cnt_d != '0) partial_o <= 1'b1;
          end
        end
        default: frame_q <= IDLE;
      endcase
    end
  end

  // Holding buffer and Wishbone write FSM
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_q          <= W_IDLE;
      pend_q        <= 1'b0;
      lane_q        <= '0;
      grp_adr_q     <= '0;
      words_o       <= '0;
      sram_wb_cyc_o <= 1'b0;
      sram_wb_stb_o <= 1'b0;
      sram_wb_we_o  <= 1'b0;
      sram_wb_adr_o <= '0;
      sram_wb_dat_o <= '0;
      for (int l = 0; l < LANES; l++) buf_q[l] <= '0;
    end else begin
      if (grp_done_q) begin
        for (int l = 0; l < LANES; l++) buf_q[l] <= shift_q[l];
        grp_adr_q <= adr_cnt_q;
        pend_q    <= 1'b1;
      end
      if (frame_start) words_o <= '0;

      case (wr_q)
        W_IDLE: begin
          if (pend_q) begin
            wr_q          <= W_WRITE;
            lane_q        <= '0;
            sram_wb_cyc_o <= 1'b1;
            sram_wb_stb_o <= 1'b1;
            sram_wb_we_o  <= 1'b1;
            sram_wb_adr_o <= grp_adr_q;
            sram_wb_dat_o <= buf_q[0];
          end
        end
        W_WRITE: begin
          if (sram_wb_ack_i) begin
            words_o <= (frame_start ? '0 : words_o) + ADDR_W'(1);
            if (lane_q == LW'(LANES-1)) begin
              wr_q          <= W_IDLE;
              pend_q        <= 1'b0;
              sram_wb_cyc_o <= 1'b0;
              sram_wb_stb_o <= 1'b0;
              sram_wb_we_o  <= 1'b0;
            end else begin
              lane_q        <= lane_q + LW'(1);
              sram_wb_adr_o <= grp_adr_q + ADDR_W'(lane_q) + ADDR_W'(1);
              sram_wb_dat_o <= buf_q[lane_q + LW'(1)];
            end
          end
        end
        default: wr_q <= W_IDLE;
      endcase
    end
  end

  assign busy_o = (frame_q == FRAME) || pend_q;

endmodule

// File: tb/tb_serial_sram_writer.sv
// Directed self-checking bench for serial_sram_writer. Expected Wishbone
// writes are queued when a word group is sent and compared as the slave
// model acknowledges each write.
module tb_serial_sram_writer;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int LANES  = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] base_adr = '0;
  logic              s_clk = 1'b0;
  logic              s_cyc = 1'b0;
  logic [LANES-1:0]  s_dat = '0;
  logic              wb_cyc, wb_stb, wb_we;
  logic [ADDR_W-1:0] wb_adr;
  logic [DATA_W-1:0] wb_dat;
  logic              slave_ack = 1'b0;
  logic              stray_ack = 1'b0;
  logic              wb_ack;
  logic              busy, overrun, partial;
  logic [ADDR_W-1:0] words;

  int  errors = 0;
  int  checks = 0;
  int  half = 4;        // serial half-period in wb_clk cycles
  int  ack_delay = 1;
  int  ack_cnt = 0;
  wr_t exp_q[$];

  assign wb_ack = slave_ack | stray_ack;

  serial_sram_writer dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .base_adr_i    (base_adr),
    .serial_clk_i  (s_clk),
    .serial_cyc_i  (s_cyc),
    .serial_dat_i  (s_dat),
    .sram_wb_cyc_o (wb_cyc),
    .sram_wb_stb_o (wb_stb),
    .sram_wb_we_o  (wb_we),
    .sram_wb_adr_o (wb_adr),
    .sram_wb_dat_o (wb_dat),
    .sram_wb_ack_i (wb_ack),
    .busy_o        (busy),
    .overrun_o     (overrun),
    .partial_o     (partial),
    .words_o       (words)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model and scoreboard: acks ack_delay cycles after stb rises and
  // compares the write being acknowledged against the queue head.
  always @(negedge clk) begin
    if (slave_ack) begin
      slave_ack = 1'b0;
      ack_cnt   = 0;
    end else if (wb_cyc && wb_stb && !rst) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        wr_t e;
        slave_ack = 1'b1;
        check("write_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_adr", 32'(wb_adr), 32'(e.adr));
          check("wr_dat", 32'(wb_dat), 32'(e.dat));
          check("wr_we", 32'(wb_we), 1);
        end
      end
    end else begin
      ack_cnt = 0;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_group(input logic [ADDR_W-1:0] adr,
                              input logic [DATA_W-1:0] w0, w1, w2);
    wr_t e;
    e.adr = adr;                e.dat = w0; exp_q.push_back(e);
    e.adr = adr + ADDR_W'(1);   e.dat = w1; exp_q.push_back(e);
    e.adr = adr + ADDR_W'(2);   e.dat = w2; exp_q.push_back(e);
  endtask

  task automatic start_frame(input logic [ADDR_W-1:0] base);
    base_adr = base;
    s_clk    = 1'b0;
    s_cyc    = 1'b1;
    wait_cycles(8);
  endtask

  task automatic end_frame();
    s_clk = 1'b0;
    wait_cycles(half);
    s_cyc = 1'b0;
    wait_cycles(8);
  endtask

  // Sends nbits per lane, MSB first; with coincide set, the final rising
  // serial edge is launched together with cyc falling.
  task automatic send_bits(input logic [DATA_W-1:0] w0, w1, w2,
                           input int nbits, input bit coincide);
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx   = DATA_W - 1 - (i % DATA_W);
      s_dat = {w2[idx], w1[idx], w0[idx]};
      s_clk = 1'b0;
      wait_cycles(half);
      s_clk = 1'b1;
      if (coincide && i == nbits - 1) s_cyc = 1'b0;
      wait_cycles(half);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < budget), 1);
    wait_cycles(4);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cyc"}, 32'(wb_cyc), 0);
    check({tag, "_stb"}, 32'(wb_stb), 0);
    check({tag, "_we"}, 32'(wb_we), 0);
    check({tag, "_adr"}, 32'(wb_adr), 0);
    check({tag, "_dat"}, 32'(wb_dat), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
    check({tag, "_partial"}, 32'(partial), 0);
    check({tag, "_words"}, 32'(words), 0);
  endtask

  initial begin
    int n;
    // Reset state
    wait_cycles(4);
    check_all_zero("reset");
    rst = 1'b0;
    wait_cycles(8);

    // Single group
    ack_delay = 1;
    expect_group(18'h00100, 16'hA5A5, 16'h1234, 16'hFFFF);
    start_frame(18'h00100);
    check("single_busy_in_frame", 32'(busy), 1);
    send_bits(16'hA5A5, 16'h1234, 16'hFFFF, 16, 1'b0);
    end_frame();
    wait_idle("single_done", 500);
    check("single_words", 32'(words), 3);
    check("single_busy", 32'(busy), 0);
    check("single_partial", 32'(partial), 0);
    stray_ack = 1'b1;
    wait_cycles(1);
    stray_ack = 1'b0;
    wait_cycles(2);
    check("stray_ack_words", 32'(words), 3);

    // Address wrap
    expect_group(18'h3FFFE, 16'h1111, 16'h2222, 16'h3333);
    expect_group(18'h00001, 16'h4444, 16'h5555, 16'h6666);
    start_frame(18'h3FFFE);
    send_bits(16'h1111, 16'h2222, 16'h3333, 16, 1'b0);
    send_bits(16'h4444, 16'h5555, 16'h6666, 16, 1'b0);
    end_frame();
    wait_idle("wrap_done", 1000);
    check("wrap_words", 32'(words), 6);
    check("wrap_overrun", 32'(overrun), 0);

    // Overrun: slow slave, fastest legal serial clock
    ack_delay = 200;
    half      = 3;
    expect_group(18'h00200, 16'hDEAD, 16'hBEEF, 16'hC0DE);
    start_frame(18'h00200);
    send_bits(16'hDEAD, 16'hBEEF, 16'hC0DE, 16, 1'b0);
    send_bits(16'h7777, 16'h8888, 16'h9999, 16, 1'b0);
    end_frame();
    wait_idle("overrun_done", 3000);
    check("overrun_flag", 32'(overrun), 1);
    check("overrun_words", 32'(words), 3);
    ack_delay = 1;
    half      = 4;
    expect_group(18'h00300, 16'h0F0F, 16'hF0F0, 16'h5A5A);
    start_frame(18'h00300);
    check("overrun_cleared", 32'(overrun), 0);
    check("words_cleared", 32'(words), 0);
    send_bits(16'h0F0F, 16'hF0F0, 16'h5A5A, 16, 1'b0);
    end_frame();
    wait_idle("after_overrun_done", 500);
    check("after_overrun_words", 32'(words), 3);

    // Partial trailing word
    expect_group(18'h00400, 16'h8001, 16'h4002, 16'h2004);
    start_frame(18'h00400);
    send_bits(16'h8001, 16'h4002, 16'h2004, 16, 1'b0);
    send_bits(16'hFFFF, 16'h0000, 16'hAAAA, 5, 1'b0);
    end_frame();
    wait_idle("partial_done", 500);
    check("partial_flag", 32'(partial), 1);
    check("partial_words", 32'(words), 3);

    // Reset while a write waits for ack; frame stays active across reset
    ack_delay = 1000;
    start_frame(18'h00500);
    send_bits(16'h1357, 16'h2468, 16'h9ABC, 16, 1'b0);
    s_clk = 1'b0;
    n = 0;
    while (!wb_stb && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_stb_seen", 32'(n < 200), 1);
    rst = 1'b1;
    wait_cycles(1);
    check_all_zero("rst_mid");
    wait_cycles(3);
    rst = 1'b0;
    ack_delay = 1;
    wait_cycles(8);
    send_bits(16'h1111, 16'h1111, 16'h1111, 16, 1'b0);
    s_clk = 1'b0;
    wait_cycles(20);
    check("rst_stale_busy", 32'(busy), 0);
    check("rst_stale_words", 32'(words), 0);
    s_cyc = 1'b0;
    wait_cycles(8);
    expect_group(18'h00600, 16'hCAFE, 16'hF00D, 16'hBABE);
    start_frame(18'h00600);
    send_bits(16'hCAFE, 16'hF00D, 16'hBABE, 16, 1'b0);
    end_frame();
    wait_idle("rst_rearm_done", 500);
    check("rst_rearm_words", 32'(words), 3);

    // Last serial edge coincides with cyc falling
    expect_group(18'h00700, 16'h0123, 16'h4567, 16'h89AB);
    start_frame(18'h00700);
    send_bits(16'h0123, 16'h4567, 16'h89AB, 16, 1'b1);
    wait_cycles(half);
    s_clk = 1'b0;
    wait_cycles(8);
    wait_idle("coincide_done", 500);
    check("coincide_partial", 32'(partial), 0);
    check("coincide_words", 32'(words), 3);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
